// File: rtl/odyssey_video_pkg.sv
// Shared types and default timing constants for the Odyssey video framer.
//
// Contents:
//   lock_state_t  - timing-lock FSM states
//   tint_t        - noise-colour tint selector encoding
//   DEF_*         - default active-window counter values
//   tint_channel  - per-channel tint mux helper
package odyssey_video_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } lock_state_t;

  typedef enum logic [1:0] {
    TINT_WHITE,
    TINT_RED,
    TINT_GREEN,
    TINT_BLUE
  } tint_t;

  localparam int unsigned DEF_H_DE_START = 88;
  localparam int unsigned DEF_H_DE_END   = 1147;
  localparam int unsigned DEF_V_DE_START = 34;
  localparam int unsigned DEF_V_DE_END   = 240;

  // A channel carries the luminance when white is selected or when the tint names it.
  function automatic logic [7:0] tint_channel(input tint_t      sel,
                                              input tint_t      chan,
                                              input logic [7:0] video);
    return ((sel == TINT_WHITE) || (sel == chan)) ? video : 8'd0;
  endfunction

endpackage

// File: rtl/odyssey_sync_edge.sv
// Falling-edge detector for the core's HSync, with VSync sampled on each HSync fall.
//
// Ports:
//   i_clk, i_reset_n - clock, asynchronous active-low reset
//   i_hsync, i_vsync - raw syncs from the core, active high
//   o_hs_d           - hsync delayed one clock (also the aligned hs output)
//   o_hs_fall        - hsync fell this cycle (combinational from the delay register)
//   o_vs_fall        - vsync was high at the previous hs_fall and is low at this one
module odyssey_sync_edge (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_hsync,
  input  logic i_vsync,
  output logic o_hs_d,
  output logic o_hs_fall,
  output logic o_vs_fall
);

  logic r_hs_d;
  logic r_vs_l;
  logic w_hs_fall;

  assign w_hs_fall = r_hs_d & ~i_hsync;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hs_d <= 1'b0;
      r_vs_l <= 1'b0;
    end else begin
      r_hs_d <= i_hsync;
      if (w_hs_fall) begin
        r_vs_l <= i_vsync;
      end
    end
  end

  assign o_hs_d    = r_hs_d;
  assign o_hs_fall = w_hs_fall;
  // Evaluated against the vsync level latched on the previous line, so a vsync that
  // drops in the same cycle as hsync still registers on this line.
  assign o_vs_fall = w_hs_fall & r_vs_l & ~i_vsync;

endmodule

// File: rtl/odyssey_video_framer.sv
// Video framer between the Odyssey core's raw sync/video and the VGA outputs.
// Generates HBlank/VBlank/DE from sync-aligned counters, measures line period and
// lines per frame, tracks timing lock, and applies the tint. All video outputs are
// registered with one clock of latency so sync and pixels stay aligned.
//
// Optional build macro: ODYSSEY_FRAMER_LOCK_GATE_EN
//   defined   - de and r/g/b are held at 0 while o_locked is low
//   undefined - de and r/g/b ignore lock; o_locked is still generated
//
// Ports:
//   i_clk, i_reset_n   - clock (pixel enable every cycle), async active-low reset
//   i_hsync, i_vsync   - raw syncs, active high
//   i_video, i_tint    - luminance and tint select (0 white, 1 red, 2 green, 3 blue)
//   o_hblank, o_vblank - registered blanking
//   o_de               - registered ~(hblank | vblank)
//   o_hs, o_vs         - syncs delayed to match
//   o_r, o_g, o_b      - tinted video
//   o_line_period      - last measured clocks per line
//   o_frame_lines      - last measured lines per frame
//   o_locked           - timing stable
module odyssey_video_framer
  import odyssey_video_pkg::*;
#(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned H_DE_START = DEF_H_DE_START,
  parameter int unsigned H_DE_END   = DEF_H_DE_END,
  parameter int unsigned V_DE_START = DEF_V_DE_START,
  parameter int unsigned V_DE_END   = DEF_V_DE_END,
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic [7:0]       i_video,
  input  logic [1:0]       i_tint,
  output logic             o_hblank,
  output logic             o_vblank,
  output logic             o_de,
  output logic             o_hs,
  output logic             o_vs,
  output logic [7:0]       o_r,
  output logic [7:0]       o_g,
  output logic [7:0]       o_b,
  output logic [CNT_W-1:0] o_line_period,
  output logic [CNT_W-1:0] o_frame_lines,
  output logic             o_locked
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HStart = CNT_W'(H_DE_START);
  localparam logic [CNT_W-1:0] HEnd   = CNT_W'(H_DE_END);
  localparam logic [CNT_W-1:0] VStart = CNT_W'(V_DE_START);
  localparam logic [CNT_W-1:0] VEnd   = CNT_W'(V_DE_END);

  localparam int unsigned     MatchW   = (LOCK_LINES > 1) ? $clog2(LOCK_LINES) : 1;
  localparam logic [MatchW-1:0] MatchTop = MatchW'(LOCK_LINES - 1);

  // Sync edges
  logic w_hs_d;
  logic w_hs_fall;
  logic w_vs_fall;

  odyssey_sync_edge u_sync_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_hsync   (i_hsync),
    .i_vsync   (i_vsync),
    .o_hs_d    (w_hs_d),
    .o_hs_fall (w_hs_fall),
    .o_vs_fall (w_vs_fall)
  );

  // Counters and measurements
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic [CNT_W-1:0] r_line_period;
  logic [CNT_W-1:0] r_frame_lines;
  logic             w_hcnt_sat;
  logic [CNT_W-1:0] w_hcnt_inc;
  logic [CNT_W-1:0] w_vcnt_inc;

  assign w_hcnt_sat = (r_hcnt == CntMax);
  // Saturating increments double as the "count + 1" measurement values.
  assign w_hcnt_inc = w_hcnt_sat ? r_hcnt : r_hcnt + CNT_W'(1);
  assign w_vcnt_inc = (r_vcnt == CntMax) ? r_vcnt : r_vcnt + CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_line_period <= '0;
      r_frame_lines <= '0;
    end else if (w_hs_fall) begin
      r_hcnt        <= '0;
      r_line_period <= w_hcnt_inc;
      if (w_vs_fall) begin
        r_vcnt        <= '0;
        r_frame_lines <= w_vcnt_inc;
      end else begin
        r_vcnt <= w_vcnt_inc;
      end
    end else begin
      r_hcnt <= w_hcnt_inc;
    end
  end

  // Blanking: edge-triggered on counter values and held otherwise, so counter
  // clears never disturb the current level.
  logic w_hblank_d;
  logic w_vblank_d;

  always_comb begin
    w_hblank_d = o_hblank;
    if (r_hcnt == HStart) begin
      w_hblank_d = 1'b0;
    end else if (r_hcnt == HEnd) begin
      w_hblank_d = 1'b1;
    end
  end

  always_comb begin
    w_vblank_d = o_vblank;
    if (r_vcnt == VStart) begin
      w_vblank_d = 1'b0;
    end else if (r_vcnt == VEnd) begin
      w_vblank_d = 1'b1;
    end
  end

  // Output pipeline stage
  logic       r_de;
  logic       r_vs;
  logic [7:0] r_r;
  logic [7:0] r_g;
  logic [7:0] r_b;
  tint_t      w_tint;

  assign w_tint = tint_t'(i_tint);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_hblank <= 1'b1;
      o_vblank <= 1'b1;
      r_de     <= 1'b0;
      r_vs     <= 1'b0;
      r_r      <= 8'd0;
      r_g      <= 8'd0;
      r_b      <= 8'd0;
    end else begin
      o_hblank <= w_hblank_d;
      o_vblank <= w_vblank_d;
      r_de     <= ~(w_hblank_d | w_vblank_d);
      r_vs     <= i_vsync;
      r_r      <= tint_channel(w_tint, TINT_RED, i_video);
      r_g      <= tint_channel(w_tint, TINT_GREEN, i_video);
      r_b      <= tint_channel(w_tint, TINT_BLUE, i_video);
    end
  end

  // Lock FSM
  lock_state_t      r_state;
  logic [MatchW-1:0] r_match;
  logic [CNT_W-1:0] r_ref_lines;
  logic             r_ref_valid;
  logic             r_locked;
  logic             w_lp_eq;
  logic             w_fl_eq;

  assign w_lp_eq = (w_hcnt_inc == r_line_period);
  assign w_fl_eq = (w_vcnt_inc == r_ref_lines);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= SEARCH;
      r_match     <= '0;
      r_ref_lines <= '0;
      r_ref_valid <= 1'b0;
      r_locked    <= 1'b0;
    end else if (w_hcnt_sat && !w_hs_fall) begin
      // No hsync for a full counter range: timing is lost.
      r_state     <= SEARCH;
      r_match     <= '0;
      r_ref_valid <= 1'b0;
      r_locked    <= 1'b0;
    end else if (w_hs_fall) begin
      case (r_state)
        SEARCH: begin
          r_state     <= MEASURE;
          r_match     <= '0;
          r_ref_valid <= 1'b0;
        end
        MEASURE: begin
          if (!w_lp_eq) begin
            r_match     <= '0;
            r_ref_valid <= 1'b0;
          end else if (r_match != MatchTop) begin
            r_match <= r_match + MatchW'(1);
          end else if (w_vs_fall) begin
            // First frame boundary after line stability captures the reference;
            // a second matching frame confirms lock.
            if (r_ref_valid && w_fl_eq) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_ref_lines <= w_vcnt_inc;
              r_ref_valid <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (!w_lp_eq || (w_vs_fall && !w_fl_eq)) begin
            r_state     <= SEARCH;
            r_match     <= '0;
            r_ref_valid <= 1'b0;
            r_locked    <= 1'b0;
          end
        end
        default: begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign o_hs          = w_hs_d;
  assign o_vs          = r_vs;
  assign o_line_period = r_line_period;
  assign o_frame_lines = r_frame_lines;
  assign o_locked      = r_locked;

`ifdef ODYSSEY_FRAMER_LOCK_GATE_EN
  // Gate after the register so pixels never leak in a cycle where locked is low.
  assign o_de = r_de & r_locked;
  assign o_r  = r_locked ? r_r : 8'd0;
  assign o_g  = r_locked ? r_g : 8'd0;
  assign o_b  = r_locked ? r_b : 8'd0;
`else
  assign o_de = r_de;
  assign o_r  = r_r;
  assign o_g  = r_g;
  assign o_b  = r_b;
`endif

endmodule

// File: doc/odyssey_video_framer.md
Name: odyssey_video_framer

Overview:
- Sits directly downstream of the Odyssey core, between its raw HSync/VSync/video outputs and the emu VGA_* outputs.
- Derives HBlank/VBlank/DE from free-running counters that are re-aligned on sync edges.
- Measures line period and lines-per-frame, and runs a lock FSM on those measurements.
- Applies the noise-colour tint and registers all video outputs with matched latency.

Parameters:
- CNT_W, 12, width of the horizontal and vertical counters and of the measurement outputs.
- H_DE_START, 88, hcnt value at which hblank deasserts.
- H_DE_END, 1147, hcnt value at which hblank asserts.
- V_DE_START, 34, vcnt value at which vblank deasserts.
- V_DE_END, 240, vcnt value at which vblank asserts.
- LOCK_LINES, 4, number of consecutive equal line periods required before frame checking starts.

Ports:
- clk  in  1  system/video clock (clk_sys); pixel enable is 1 every cycle.
- reset_n  in  1  asynchronous active-low reset.
- hsync_in  in  1  raw HSync from core, active high.
- vsync_in  in  1  raw VSync from core, active high.
- video_in  in  8  luminance from core.
- tint  in  2  0=white, 1=red, 2=green, 3=blue.
- hblank  out  1  registered horizontal blank.
- vblank  out  1  registered vertical blank.
- de  out  1  ~(hblank|vblank), registered.
- hs_out  out  1  hsync_in delayed to match.
- vs_out  out  1  vsync_in delayed to match.
- r, g, b  out  8 each  tinted video.
- line_period  out  CNT_W  last measured clocks per line.
- frame_lines  out  CNT_W  last measured lines per frame.
- locked  out  1  timing stable.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset values: hcnt=0, vcnt=0, hblank=1, vblank=1, de=0, hs_out=0, vs_out=0, r/g/b=0, line_period=0, frame_lines=0, locked=0, FSM=SEARCH.
- Edge detect:
  - hs_fall = hs_d & ~hsync_in, where hs_d is a 1-cycle register.
  - vsync is sampled only on hs_fall into vs_l.
  - vs_fall = vs_l & ~vsync_in, evaluated on hs_fall.
- hcnt:
  - Increments by 1 each cycle and saturates at 2^CNT_W-1.
  - On hs_fall: hcnt<=0 and line_period<=hcnt+1, using the pre-clear value plus one.
- vcnt:
  - Increments on hs_fall and saturates.
  - On hs_fall with vs_fall: vcnt<=0 and frame_lines<=vcnt+1.
  - Simultaneous hsync and vsync falling edges in the same cycle count as a vs_fall on that line.
- hblank:
  - Clears the cycle after hcnt==H_DE_START.
  - Sets the cycle after hcnt==H_DE_END.
  - Holds otherwise, so it is level-preserving across counter clears.
- vblank: same rule on vcnt with V_DE_START and V_DE_END.
- Latency: all outputs (hblank, vblank, de, hs_out, vs_out, r, g, b) are exactly 1 clk after the inputs they derive from; video and sync stay aligned.
- Tint: each channel = video_in when tint==0 or tint selects that channel, else 8'd0.
- Lock FSM, state changes evaluated on hs_fall:
  - SEARCH: on hs_fall → MEASURE, clear match counter.
  - MEASURE:
    - If new line_period equals previous, increment match counter; else clear it.
    - When match counter reaches LOCK_LINES-1, wait for a vs_fall; capture frame_lines as ref.
    - On the next vs_fall, if frame_lines equals ref → LOCKED; else re-capture ref.
  - LOCKED:
    - Any line_period change → SEARCH.
    - frame_lines change at vs_fall → SEARCH.
  - Any state: hcnt saturating (no hsync for 2^CNT_W-1 clocks) → SEARCH.
  - locked = (state==LOCKED), registered.
- Reset asserted mid-line: outputs return to reset values immediately; measurement restarts from SEARCH.

Optional Feature:
- Macro: ODYSSEY_FRAMER_LOCK_GATE_EN.
- Defined: de is forced 0 and r/g/b forced 0 while locked==0; hs_out and vs_out still pass through.
- Undefined: de and r/g/b ignore locked; locked is still generated.

Decomposition:
- Package odyssey_video_pkg:
  - typedef enum lock_state_t {SEARCH, MEASURE, LOCKED}.
  - typedef enum tint_t {TINT_WHITE, TINT_RED, TINT_GREEN, TINT_BLUE}.
  - Default window constants 88, 1147, 34, 240.
- Sub-module odyssey_sync_edge: registered falling-edge detector for hsync, plus sampling of vsync on the hsync edge. Instantiated once.
- Counters, blank generation, lock FSM and tint mux stay in the top module.

Test Plan:
- Reset release, then hsync period 1270 clks (pulse 90): line_period=1270 after the second hs_fall; hblank deasserts 89 clks after hcnt clear and reasserts at hcnt 1148.
- 262-line frames, vsync 3 lines: vblank clears at line 35 and sets at line 241; frame_lines=262; locked=1 after 4 lines plus 2 frames.
- Locked stream, one line shortened to 1269: locked drops on that hs_fall, then re-locks after a stable resequence.
- hsync stopped for 4100 clks: hcnt holds at 4095 and locked=0.
- tint=2, video_in=8'hA5: g=8'hA5, r=0, b=0 one clk later; tint=0 gives all three 8'hA5.
- reset_n pulsed low mid-line: de=0, r/g/b=0 and locked=0 asynchronously. With ODYSSEY_FRAMER_LOCK_GATE_EN defined, de stays 0 until re-lock.
